spi_master_param: RTL and testbench

Parametrised SPI master: next generation of the fixed 8-bit, single-slave SPI top. Adds configurable word width, programmable SCLK divider, NUM_CS one-hot active-low chip selects, LSB/MSB-first ordering, and explicit CS setup/hold phases. Sits between the local control FSM and the off-chip SPI pins; single clock domain.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clk_gen.sv | 58 +++++
 rtl/spi_master_param.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and width helper for the parametrised SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_TRANSFER = 3'd2,
      S_HOLD     = 3'd3,
      S_DONE     = 3'd4
   } spi_state_e;

   // ceil(log2(n)) clamped to 1 so a single-entry range still gets a real bit
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      if (w < 32'sd1) begin
         w = 32'sd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider and edge counter; strobes mark the clk cycle whose
// closing edge toggles sclk, so the FSM acts on the same edge as the toggle.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_cpol,
   output logic o_sclk,
   output logic o_lead_stb,
   output logic o_trail_stb,
   output logic o_last_edge
);

   localparam int DIV_W  = clog2_min1(CLK_DIV);
   localparam int EDGE_W = clog2_min1(2 * DATA_W);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   logic [DIV_W-1:0]  r_div_cnt;
   logic [EDGE_W-1:0] r_edge_cnt;
   logic              r_sclk;
   logic              w_tick;

   // Edge strobes; even edge count before the toggle means a leading edge
   always_comb begin
      w_tick      = i_en && (r_div_cnt == DIV_LAST);
      o_lead_stb  = w_tick && !r_edge_cnt[0];
      o_trail_stb = w_tick && r_edge_cnt[0];
      o_last_edge = w_tick && (r_edge_cnt == EDGE_LAST);
   end

   // Divider and edge counter; while disabled sclk is reloaded with the idle level
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_sclk     <= 1'b0;
      end else if (!i_en) begin
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_sclk     <= i_cpol;
      end else if (w_tick) begin
         r_div_cnt  <= '0;
         r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
         r_sclk     <= ~r_sclk;
      end else begin
         r_div_cnt  <= r_div_cnt + DIV_W'(1);
      end
   end

   assign o_sclk = r_sclk;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: transfer FSM, shift registers and one-hot
// active-low chip-select decode. Single clock domain, synchronous reset.
module spi_master_param
   import spi_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int NUM_CS  = 4,
   parameter  int CLK_DIV = 4,
   localparam int CS_W    = clog2_min1(NUM_CS)
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_start,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic              i_lsb_first,
   input  logic [CS_W-1:0]   i_cs_sel,
   input  logic [DATA_W-1:0] i_din,
   output logic [DATA_W-1:0] o_dout,
   output logic              o_tx_done,
   output logic              o_rx_done,
   output logic              o_busy,
   output logic [NUM_CS-1:0] o_cs_n,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso
);

   localparam int CNT_W = clog2_min1(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   spi_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_dout;
   logic [NUM_CS-1:0] r_cs_n;
   logic              r_cpol;
   logic              r_cpha;
   logic              r_lsb;
   logic              r_mosi;
   logic              r_busy;
   logic              r_tx_done;
   logic              r_rx_done;

   logic              w_en;
   logic              w_cpol;
   logic              w_sclk;
   logic              w_lead;
   logic              w_trail;
   logic              w_last;
   logic              w_sample;
   logic              w_shift;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   // r_tx always holds the unsent bits with the next one at the outgoing end
   function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b,
                                                  input logic lsb);
      return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   // Out-of-range selects match no entry and leave every line deasserted
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (sel == CS_W'(i)) begin
            v[i] = 1'b0;
         end else begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Divider control and which edges sample miso vs. advance mosi
   always_comb begin
      w_en     = (r_state == S_TRANSFER);
      w_cpol   = (r_state == S_IDLE) ? i_cpol : r_cpol;
      w_sample = w_en && (r_cpha ? w_trail : w_lead);
      w_shift  = w_en && (r_cpha ? w_lead : (w_trail && !w_last));
   end

   spi_clk_gen #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .i_clk       (i_clk),
      .i_rst       (i_arst),
      .i_en        (w_en),
      .i_cpol      (w_cpol),
      .o_sclk      (w_sclk),
      .o_lead_stb  (w_lead),
      .o_trail_stb (w_trail),
      .o_last_edge (w_last)
   );

   // Transfer FSM with all datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_dout    <= '0;
         r_cs_n    <= '1;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_lsb     <= 1'b0;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
         r_rx_done <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         r_rx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_mosi <= 1'b0;
               if (i_start) begin
                  r_cpol  <= i_cpol;
                  r_cpha  <= i_cpha;
                  r_lsb   <= i_lsb_first;
                  r_cs_n  <= cs_decode(i_cs_sel);
                  r_rx    <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
                  // cpha=0 must present the first bit before the first leading edge
                  if (i_cpha) begin
                     r_tx   <= i_din;
                     r_mosi <= 1'b0;
                  end else begin
                     r_tx   <= drop_bit(i_din, i_lsb_first);
                     r_mosi <= first_bit(i_din, i_lsb_first);
                  end
               end
            end
            S_SETUP: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_TRANSFER;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_TRANSFER: begin
               if (w_sample) begin
                  r_rx <= push_bit(r_rx, i_miso, r_lsb);
               end
               if (w_shift) begin
                  r_mosi <= first_bit(r_tx, r_lsb);
                  r_tx   <= drop_bit(r_tx, r_lsb);
               end
               if (w_last) begin
                  r_tx_done <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt     <= '0;
                  r_cs_n    <= '1;
                  r_busy    <= 1'b0;
                  r_mosi    <= 1'b0;
                  r_dout    <= r_rx;
                  r_rx_done <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt     <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cs_n  <= '1;
               r_busy  <= 1'b0;
               r_mosi  <= 1'b0;
            end
         endcase
      end
   end

   assign o_dout    = r_dout;
   assign o_tx_done = r_tx_done;
   assign o_rx_done = r_rx_done;
   assign o_busy    = r_busy;
   assign o_cs_n    = r_cs_n;
   assign o_sclk    = w_sclk;
   assign o_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench: two configurations of spi_master_param against a
// bit-level slave model and cycle-count expectations from the transfer rules.
module tb_spi_master_param;

   localparam int AW   = 8;
   localparam int ADIV = 4;
   localparam int BW   = 16;
   localparam int BDIV = 1;
   localparam int A_RX = 2 * ADIV * (AW + 1) + 1;
   localparam int B_RX = 2 * BDIV * (BW + 1) + 1;

   logic clk;
   logic arst;
   int   checks;
   int   errors;

   logic          a_start, a_cpol, a_cpha, a_lsb, a_tx_done, a_rx_done, a_busy, a_sclk, a_mosi, a_miso;
   logic [1:0]    a_cs_sel;
   logic [AW-1:0] a_din, a_dout;
   logic [2:0]    a_cs_n;

   logic          b_start, b_cpol, b_cpha, b_lsb, b_tx_done, b_rx_done, b_busy, b_sclk, b_mosi, b_miso;
   logic [0:0]    b_cs_sel;
   logic [BW-1:0] b_din, b_dout;
   logic [0:0]    b_cs_n;

   // slave model for DUT A: bit index derived from the SCLK edges seen so far
   logic          m_loop, m_cpha, m_lsb;
   logic [AW-1:0] m_word;
   int            m_edges;
   int            a_idx;

   logic          prev_s;
   int            n, nrx, gap, n_done;
   logic [AW-1:0] btb_word;

   spi_master_param #(.DATA_W(AW), .NUM_CS(3), .CLK_DIV(ADIV)) u_dut_a (
      .i_clk(clk), .i_arst(arst), .i_start(a_start), .i_cpol(a_cpol), .i_cpha(a_cpha),
      .i_lsb_first(a_lsb), .i_cs_sel(a_cs_sel), .i_din(a_din), .o_dout(a_dout),
      .o_tx_done(a_tx_done), .o_rx_done(a_rx_done), .o_busy(a_busy), .o_cs_n(a_cs_n),
      .o_sclk(a_sclk), .o_mosi(a_mosi), .i_miso(a_miso)
   );

   spi_master_param #(.DATA_W(BW), .NUM_CS(1), .CLK_DIV(BDIV)) u_dut_b (
      .i_clk(clk), .i_arst(arst), .i_start(b_start), .i_cpol(b_cpol), .i_cpha(b_cpha),
      .i_lsb_first(b_lsb), .i_cs_sel(b_cs_sel), .i_din(b_din), .o_dout(b_dout),
      .o_tx_done(b_tx_done), .o_rx_done(b_rx_done), .o_busy(b_busy), .o_cs_n(b_cs_n),
      .o_sclk(b_sclk), .o_mosi(b_mosi), .i_miso(b_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      a_idx = 0;
      if (m_cpha) a_idx = (m_edges > 0) ? (m_edges - 1) / 2 : 0;
      else        a_idx = m_edges / 2;
      if (a_idx > AW - 1) a_idx = AW - 1;
      a_miso = m_loop ? a_mosi : (m_lsb ? m_word[a_idx] : m_word[AW - 1 - a_idx]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer_a(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] sel,
                         input logic [AW-1:0] din, input logic [AW-1:0] slave, input logic loop,
                         input string tag);
      int            cyc, rx_cyc, busy_n, tx_n, ncap;
      logic          p_sclk, p_mosi, cs_ok;
      logic [2:0]    exp_cs;
      logic [AW-1:0] cap_w, got;
      exp_cs = 3'b111;
      if (sel < 2'd3) exp_cs[sel] = 1'b0;
      a_cpol = cpol; m_cpha = cpha; m_lsb = lsb; m_word = slave; m_loop = loop; m_edges = 0;
      repeat (2) @(negedge clk);
      chk({tag, " idle sclk"}, 32'(a_sclk), 32'(cpol));
      a_cpha = cpha; a_lsb = lsb; a_cs_sel = sel; a_din = din; a_start = 1'b1;
      p_sclk = a_sclk; p_mosi = a_mosi;
      cyc = 0; rx_cyc = -1; busy_n = 0; tx_n = 0; ncap = 0; cap_w = '0; got = '0; cs_ok = 1'b1;
      while (rx_cyc < 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            // late input changes must not reach the transfer in flight
            a_start = 1'b0; a_din = AW'($urandom); a_cpha = ~cpha; a_lsb = ~lsb;
            a_cs_sel = 2'($urandom);
            chk({tag, " setup mosi"}, 32'(a_mosi), 32'(cpha ? 1'b0 : (lsb ? din[0] : din[AW-1])));
         end
         if (a_sclk !== p_sclk) begin
            m_edges++;
            if (((m_edges % 2) == 1) != (cpha == 1'b1)) begin
               if (ncap < AW) begin
                  if (lsb) cap_w[ncap] = p_mosi;
                  else     cap_w[AW - 1 - ncap] = p_mosi;
               end
               ncap++;
            end
         end
         p_sclk = a_sclk; p_mosi = a_mosi;
         if (a_busy) begin
            busy_n++;
            if (a_cs_n !== exp_cs) cs_ok = 1'b0;
         end else if (a_cs_n !== 3'b111) begin
            cs_ok = 1'b0;
         end
         if (a_tx_done) begin
            tx_n++;
            chk({tag, " sclk at tx_done"}, 32'(a_sclk), 32'(cpol));
         end
         if (a_rx_done) begin
            rx_cyc = cyc; got = a_dout;
            chk({tag, " mosi at done"}, 32'(a_mosi), 32'(1'b0));
         end
      end
      chk({tag, " rx_done cycle"}, 32'(rx_cyc), 32'(A_RX));
      chk({tag, " busy cycles"}, 32'(busy_n), 32'(A_RX - 1));
      chk({tag, " sclk edges"}, 32'(m_edges), 32'(2 * AW));
      chk({tag, " tx_done pulses"}, 32'(tx_n), 32'(1));
      chk({tag, " dout"}, 32'(got), 32'(loop ? din : slave));
      chk({tag, " mosi word"}, 32'(cap_w), 32'(din));
      chk({tag, " cs_n"}, 32'(cs_ok), 32'(1'b1));
      @(negedge clk);
      chk({tag, " sclk after"}, 32'(a_sclk), 32'(cpol));
      chk({tag, " dout held"}, 32'(a_dout), 32'(loop ? din : slave));
   endtask

   task automatic xfer_b(input logic cpol, input logic cpha, input logic lsb, input logic sel,
                         input logic [BW-1:0] din, input logic miso, input string tag);
      int            cyc, rx_cyc, edges, ncap;
      logic          p_sclk, p_mosi, cs_ok;
      logic [BW-1:0] cap_w, got;
      b_cpol = cpol; b_miso = miso;
      repeat (2) @(negedge clk);
      chk({tag, " idle sclk"}, 32'(b_sclk), 32'(cpol));
      b_cpha = cpha; b_lsb = lsb; b_cs_sel = sel; b_din = din; b_start = 1'b1;
      p_sclk = b_sclk; p_mosi = b_mosi;
      cyc = 0; rx_cyc = -1; edges = 0; ncap = 0; cap_w = '0; got = '0; cs_ok = 1'b1;
      while (rx_cyc < 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            b_start = 1'b0; b_din = BW'($urandom);
            chk({tag, " setup mosi"}, 32'(b_mosi), 32'(cpha ? 1'b0 : (lsb ? din[0] : din[BW-1])));
         end
         if (b_sclk !== p_sclk) begin
            edges++;
            if (((edges % 2) == 1) != (cpha == 1'b1)) begin
               if (ncap < BW) begin
                  if (lsb) cap_w[ncap] = p_mosi;
                  else     cap_w[BW - 1 - ncap] = p_mosi;
               end
               ncap++;
            end
         end
         p_sclk = b_sclk; p_mosi = b_mosi;
         if (b_busy && (b_cs_n !== {1{sel}})) cs_ok = 1'b0;
         if (b_rx_done) begin rx_cyc = cyc; got = b_dout; end
      end
      chk({tag, " rx_done cycle"}, 32'(rx_cyc), 32'(B_RX));
      chk({tag, " sclk edges"}, 32'(edges), 32'(2 * BW));
      chk({tag, " dout"}, 32'(got), 32'(miso ? {BW{1'b1}} : {BW{1'b0}}));
      chk({tag, " mosi word"}, 32'(cap_w), 32'(din));
      chk({tag, " cs_n"}, 32'(cs_ok), 32'(1'b1));
   endtask

   initial begin
      checks = 0; errors = 0;
      arst = 1'b1;
      a_start = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_lsb = 1'b0; a_cs_sel = 2'd0; a_din = '0;
      b_start = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0; b_lsb = 1'b0; b_cs_sel = 1'b0; b_din = '0;
      b_miso = 1'b0;
      m_loop = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_word = '0; m_edges = 0;
      repeat (3) @(negedge clk);
      chk("reset a cs_n", 32'(a_cs_n), 32'(3'b111));
      chk("reset a sclk", 32'(a_sclk), 32'(1'b0));
      chk("reset a busy", 32'(a_busy), 32'(1'b0));
      chk("reset a mosi", 32'(a_mosi), 32'(1'b0));
      chk("reset a dout", 32'(a_dout), 32'(0));
      chk("reset a done", 32'({a_tx_done, a_rx_done}), 32'(2'b00));
      chk("reset b cs_n", 32'(b_cs_n), 32'(1'b1));
      chk("reset b busy", 32'(b_busy), 32'(1'b0));
      arst = 1'b0;

      xfer_a(1'b0, 1'b0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, "mode0 loop");
      for (int md = 0; md < 4; md++) begin
         xfer_a(md[1], md[0], 1'b0, 2'd1, 8'h3C, 8'hC3, 1'b0, $sformatf("mode%0d", md));
      end
      xfer_a(1'b0, 1'b0, 1'b0, 2'd3, 8'h69, 8'h5B, 1'b0, "cs_sel 3");
      xfer_a(1'b0, 1'b0, 1'b1, 2'd2, 8'h81, 8'hFF, 1'b0, "lsb first");
      for (int r = 0; r < 6; r++) begin
         xfer_a(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), AW'($urandom),
                AW'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
      end

      // start held high: back-to-back transfers, one idle cycle between
      btb_word = 8'hC6; m_loop = 1'b1;
      a_cpha = 1'b0; a_lsb = 1'b0; a_cs_sel = 2'd0; a_din = btb_word; a_start = 1'b1;
      nrx = 0; gap = 0;
      for (int c = 1; c <= 240; c++) begin
         @(negedge clk);
         if (c == 200) a_start = 1'b0;
         if (a_rx_done) begin
            nrx++;
            chk("btb dout", 32'(a_dout), 32'(btb_word));
            chk("btb rx cycle", 32'(c), 32'(A_RX + (nrx - 1) * A_RX + (nrx - 1)));
         end
         if (!a_busy && !a_rx_done && c > 1 && c < 3 * A_RX + 2) begin
            gap++;
            chk("btb idle cs_n", 32'(a_cs_n), 32'(3'b111));
         end
      end
      chk("btb rx count", 32'(nrx), 32'(3));
      chk("btb idle gaps", 32'(gap), 32'(2));

      // reset in the middle of TRANSFER
      a_cpol = 1'b0; a_cpha = 1'b0; a_lsb = 1'b0; a_cs_sel = 2'd2; a_din = 8'h5A;
      m_loop = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_word = 8'h96; m_edges = 0;
      repeat (2) @(negedge clk);
      prev_s = a_sclk; a_start = 1'b1; n = 0;
      while (m_edges < 5 && n < 200) begin
         @(negedge clk);
         n++; a_start = 1'b0;
         if (a_sclk !== prev_s) m_edges++;
         prev_s = a_sclk;
      end
      chk("abort edge 5 reached", 32'(m_edges), 32'(5));
      chk("abort busy before", 32'(a_busy), 32'(1'b1));
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      chk("abort cs_n", 32'(a_cs_n), 32'(3'b111));
      chk("abort sclk", 32'(a_sclk), 32'(1'b0));
      chk("abort busy", 32'(a_busy), 32'(1'b0));
      chk("abort dout", 32'(a_dout), 32'(0));
      n_done = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_tx_done || a_rx_done || a_busy) n_done++;
      end
      chk("abort no done", 32'(n_done), 32'(0));
      xfer_a(1'b1, 1'b0, 1'b0, 2'd0, 8'hE7, 8'h1D, 1'b0, "after abort");

      xfer_b(1'b0, 1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, "b lsb16");
      xfer_b(1'b1, 1'b1, 1'b0, 1'b1, BW'($urandom), 1'b0, "b mode3 nocs");
      xfer_b(1'b0, 1'b1, 1'b1, 1'b0, BW'($urandom), 1'b1, "b mode1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
